// File: rtl/adc_capture_pkg.sv
// Shared constants for the ADC capture engine: register word addresses,
// FSM state encoding and the ID minor version.
package adc_capture_pkg;

    // Register word addresses (low three bits; upper address bits must be zero)
    localparam logic [2:0] REG_ID         = 3'd0;
    localparam logic [2:0] REG_SCRATCH    = 3'd1;
    localparam logic [2:0] REG_CTRL       = 3'd2;
    localparam logic [2:0] REG_STATUS     = 3'd3;
    localparam logic [2:0] REG_LENGTH     = 3'd4;
    localparam logic [2:0] REG_TRIG_CFG   = 3'd5;
    localparam logic [2:0] REG_TRIG_LEVEL = 3'd6;
    localparam logic [2:0] REG_COUNT      = 3'd7;

    // Capture FSM encoding, also reported in STATUS[1:0]
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [7:0] ID_MINOR = 8'h01;

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port beat buffer: one write port, one registered read port.
// No reset on the array; contents after reset are undefined.
module adc_capture_ram #(
    parameter int C_WIDTH      = 64,
    parameter int C_DEPTH_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [C_DEPTH_LOG2-1:0] waddr,
    input  logic [C_WIDTH-1:0]      wdata,
    input  logic [C_DEPTH_LOG2-1:0] raddr,
    output logic [C_WIDTH-1:0]      rdata
);
    logic [C_WIDTH-1:0] mem_q [0:(1<<C_DEPTH_LOG2)-1];
    logic [C_WIDTH-1:0] rdata_q;

    // Write on the accepting edge, read registered one cycle later
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/adc_capture.sv
// Multi-channel ADC capture engine: register decode, capture FSM and
// level-crossing trigger, with the beat buffer behind a uniform 2-cycle read.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// IDLE     | not capturing; beats discarded; ARM moves to ARMED
// ARMED    | waiting for trigger (first beat, or rising crossing of level)
// CAPTURE  | storing beats at index COUNT until COUNT reaches LENGTH
// DONE     | capture complete, DONE flag set; ARM restarts
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 11,
    parameter int C_NUM_CH     = 4,
    parameter int C_DATA_WIDTH = 16,
    parameter int C_DEPTH_LOG2 = 8
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [C_ADDR_WIDTH-1:0]          up_wr_addr,
    input  logic                             up_wr_req,
    input  logic [31:0]                      up_wr_din,
    output logic                             up_wr_ack,
    input  logic [C_ADDR_WIDTH-1:0]          up_rd_addr,
    input  logic                             up_rd_req,
    output logic [31:0]                      up_rd_dout,
    output logic                             up_rd_ack,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    output logic                             interrupt
);
    localparam int NW    = C_NUM_CH * C_DATA_WIDTH;
    localparam int DEPTH = 1 << C_DEPTH_LOG2;
    localparam int LW    = C_DEPTH_LOG2 + 1;
    localparam int OW    = C_ADDR_WIDTH - 1;
    localparam logic [OW-1:0] NCH_W = OW'(C_NUM_CH);

    logic [31:0]             scratch_q, scratch_d;
    logic                    irq_en_q, irq_en_d;
    logic [LW-1:0]           length_q, length_d;
    logic [3:0]              trig_ch_q, trig_ch_d;
    logic                    trig_mode_q, trig_mode_d;
    logic [C_DATA_WIDTH-1:0] trig_level_q, trig_level_d;
    logic [1:0]              state_q, state_d;
    logic [LW-1:0]           count_q, count_d;
    logic                    done_q, done_d;
    logic                    hist_valid_q, hist_valid_d;
    logic                    prev_below_q, prev_below_d;
    logic                    irq_q, irq_d;
    logic                    tready_q, tready_d;
    logic                    wr_ack_q, wr_ack_d;
    logic                    rd_req_q, rd_req_d;
    logic [C_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                    rd_ack_q, rd_ack_d;
    logic [31:0]             rd_dout_q, rd_dout_d;

    logic                    wr_reg;
    logic                    beat;
    logic [3:0]              trig_sel;
    logic [C_DATA_WIDTH-1:0] trig_sample;
    logic                    cur_below;
    logic                    trig_hit;
    logic                    done_set;
    logic [LW-1:0]           len_eff;
    logic                    ram_we;
    logic [C_DEPTH_LOG2-1:0] ram_waddr;
    logic [C_DEPTH_LOG2-1:0] ram_raddr;
    logic [NW-1:0]           ram_rdata;
    logic [OW-1:0]           r_off, r_beat, r_ch;
    logic signed [C_DATA_WIDTH-1:0] rd_sample;

    assign wr_reg  = up_wr_req && (up_wr_addr[C_ADDR_WIDTH-1:3] == '0);
    assign beat    = s_axis_tvalid && tready_q;
    assign len_eff = (length_q == '0 || length_q > LW'(DEPTH)) ? LW'(DEPTH) : length_q;
    assign trig_sel = (int'(trig_ch_q) < C_NUM_CH) ? trig_ch_q : 4'd0;

    // Pick the trigger channel out of the beat and compare against the level
    always_comb begin
        trig_sample = '0;
        for (int n = 0; n < C_NUM_CH; n++)
            if (int'(trig_sel) == n) trig_sample = s_axis_tdata[n*C_DATA_WIDTH +: C_DATA_WIDTH];
        cur_below = $signed(trig_sample) < $signed(trig_level_q);
    end

    // Register writes first, then the beat is processed under the resulting state
    always_comb begin
        scratch_d    = scratch_q;
        irq_en_d     = irq_en_q;
        length_d     = length_q;
        trig_ch_d    = trig_ch_q;
        trig_mode_d  = trig_mode_q;
        trig_level_d = trig_level_q;
        state_d      = state_q;
        count_d      = count_q;
        done_d       = done_q;
        hist_valid_d = hist_valid_q;
        prev_below_d = prev_below_q;
        trig_hit     = 1'b0;
        done_set     = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = '0;
        if (wr_reg) begin
            case (up_wr_addr[2:0])
                REG_SCRATCH: scratch_d = up_wr_din;
                REG_CTRL: begin
                    irq_en_d = up_wr_din[2];
                    if (up_wr_din[1]) begin
                        state_d = ST_IDLE;
                    end else if (up_wr_din[0] && (state_q == ST_IDLE || state_q == ST_DONE)) begin
                        state_d      = ST_ARMED;
                        count_d      = '0;
                        done_d       = 1'b0;
                        hist_valid_d = 1'b0;
                    end
                end
                REG_STATUS: if (up_wr_din[8]) done_d = 1'b0;
                REG_LENGTH: length_d = up_wr_din[LW-1:0];
                REG_TRIG_CFG: begin
                    trig_ch_d   = up_wr_din[3:0];
                    trig_mode_d = up_wr_din[8];
                end
                REG_TRIG_LEVEL: trig_level_d = up_wr_din[C_DATA_WIDTH-1:0];
                default: ;
            endcase
        end
        if (beat) begin
            case (state_d)
                ST_ARMED: begin
                    trig_hit     = !trig_mode_q || (hist_valid_d && prev_below_d && !cur_below);
                    hist_valid_d = 1'b1;
                    prev_below_d = cur_below;
                    if (trig_hit) begin
                        ram_we  = 1'b1;
                        count_d = LW'(1);
                        if (len_eff == LW'(1)) begin
                            state_d  = ST_DONE;
                            done_set = 1'b1;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    ram_we    = 1'b1;
                    ram_waddr = count_d[C_DEPTH_LOG2-1:0];
                    count_d   = count_d + LW'(1);
                    if (count_d == len_eff) begin
                        state_d  = ST_DONE;
                        done_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Set wins over a same-cycle W1C
        if (done_set) done_d = 1'b1;
        irq_d = done_set && irq_en_d;
    end

    // Bus handshakes: write ack next cycle, read ack two cycles after request
    always_comb begin
        wr_ack_d  = up_wr_req;
        tready_d  = 1'b1;
        rd_req_d  = up_rd_req;
        rd_addr_d = up_rd_req ? up_rd_addr : rd_addr_q;
        rd_ack_d  = rd_req_q;
        ram_raddr = C_DEPTH_LOG2'(up_rd_addr[OW-1:0] / NCH_W);
        r_off     = rd_addr_q[OW-1:0];
        r_beat    = r_off / NCH_W;
        r_ch      = r_off % NCH_W;
        rd_sample = '0;
        for (int n = 0; n < C_NUM_CH; n++)
            if (int'(r_ch) == n) rd_sample = ram_rdata[n*C_DATA_WIDTH +: C_DATA_WIDTH];
        rd_dout_d = '0;
        if (rd_req_q) begin
            if (rd_addr_q[C_ADDR_WIDTH-1:3] == '0) begin
                case (rd_addr_q[2:0])
                    REG_ID:         rd_dout_d = {8'(C_NUM_CH), 8'(C_DATA_WIDTH), 8'(C_DEPTH_LOG2), ID_MINOR};
                    REG_SCRATCH:    rd_dout_d = scratch_q;
                    REG_CTRL:       rd_dout_d = {29'b0, irq_en_q, 2'b0};
                    REG_STATUS:     rd_dout_d = {23'b0, done_q, 6'b0, state_q};
                    REG_LENGTH:     rd_dout_d = 32'(length_q);
                    REG_TRIG_CFG:   rd_dout_d = {23'b0, trig_mode_q, 4'b0, trig_ch_q};
                    REG_TRIG_LEVEL: rd_dout_d = 32'(trig_level_q);
                    default:        rd_dout_d = 32'(count_q);
                endcase
            end else if (rd_addr_q[C_ADDR_WIDTH-1] && int'(r_beat) < DEPTH) begin
                rd_dout_d = 32'(rd_sample);
            end
        end
    end

    // State and register flops
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            scratch_q    <= '0;
            irq_en_q     <= 1'b0;
            length_q     <= '0;
            trig_ch_q    <= '0;
            trig_mode_q  <= 1'b0;
            trig_level_q <= '0;
            state_q      <= ST_IDLE;
            count_q      <= '0;
            done_q       <= 1'b0;
            hist_valid_q <= 1'b0;
            prev_below_q <= 1'b0;
            irq_q        <= 1'b0;
            tready_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            rd_ack_q     <= 1'b0;
            rd_dout_q    <= '0;
        end else begin
            scratch_q    <= scratch_d;
            irq_en_q     <= irq_en_d;
            length_q     <= length_d;
            trig_ch_q    <= trig_ch_d;
            trig_mode_q  <= trig_mode_d;
            trig_level_q <= trig_level_d;
            state_q      <= state_d;
            count_q      <= count_d;
            done_q       <= done_d;
            hist_valid_q <= hist_valid_d;
            prev_below_q <= prev_below_d;
            irq_q        <= irq_d;
            tready_q     <= tready_d;
            wr_ack_q     <= wr_ack_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            rd_ack_q     <= rd_ack_d;
            rd_dout_q    <= rd_dout_d;
        end
    end

    adc_capture_ram #(
        .C_WIDTH      (NW),
        .C_DEPTH_LOG2 (C_DEPTH_LOG2)
    ) u_ram (
        .clk   (aclk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (s_axis_tdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign up_wr_ack     = wr_ack_q;
    assign up_rd_ack     = rd_ack_q;
    assign up_rd_dout    = rd_dout_q;
    assign s_axis_tready = tready_q;
    assign interrupt     = irq_q;
endmodule
